mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  E-stage multiply/divide unit holding the architectural HI/LO registers. Consumes
//  the 4-bit mult_divop and the rs/rt operands produced by the instruction decoder.
//  Executes mult/multu/div/divu over a fixed multi-cycle latency and handles mthi/mtlo
//  writes and mfhi/mflo reads. Provides start/busy to the hazard unit, which stalls
//  any MD-class instruction (is_mu_di/is_mt/is_mf) while start|busy.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (1..15)
//  DIV_CYCLES   10  busy cycles for div/divu (1..15)
// PORTS
//  clk         in   1   rising-edge clock
//  reset_n     in   1   asynchronous, active-low reset
//  en          in   1   E-stage instruction valid (not bubble/stalled)
//  mult_divop  in   4   0000 none,0001 mult,0011 multu,0010 div,0100 divu,0101 mfhi,0110 mflo,0111 mthi,1000 mtlo
//  a           in   32  rs operand (forwarded)
//  b           in   32  rt operand (forwarded)
//  cancel      in   1   abort request; present only with MDU_CANCEL_EN
//  start       out  1   comb: en & op in {mult,multu,div,divu} & !busy
//  busy        out  1   registered: operation in flight
//  hi          out  32  HI register
//  lo          out  32  LO register
//  rdata       out  32  comb: hi when op=mfhi, lo when op=mflo, else 0
// BEHAVIOUR
//  - Reset (reset_n=0, any time incl. mid-operation): hi=lo=0, cnt=0, busy=0, temp regs=0;
//    pending result discarded.
//  - State held in 4-bit down-counter cnt; IDLE when cnt==0, BUSY otherwise; busy=(cnt!=0).
//  - Start edge: cnt<=MULT_CYCLES or DIV_CYCLES; result computed from a/b of the start
//    cycle into hi_tmp/lo_tmp (operands not re-sampled later).
//  - BUSY: cnt decrements each edge; edge where cnt 1->0 commits hi<=hi_tmp, lo<=lo_tmp.
//    busy high exactly N cycles after start cycle; new HI/LO visible cycle after busy falls.
//  - Back-to-back: a start is accepted in the first cycle busy=0.
//  - mult: {hi,lo}=$signed(a)*$signed(b) (64-bit); multu: unsigned 64-bit product.
//  - div: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//    0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu: unsigned quotient/remainder.
//  - Divide by zero (b==0, div or divu): runs full DIV_CYCLES, busy behaves normally,
//    HI/LO left unchanged at commit.
//  - mthi/mtlo: when en & !busy, hi<=a / lo<=a at next edge, single cycle, no busy.
//  - mfhi/mflo: purely combinational read of current hi/lo; no state change.
//  - Any MD op with en=1 while busy=1 is a hazard-unit violation: ignored, no state change.
//  - Ops with en=0 and op=0000 have no effect. Undefined op codes are treated as 0000.
// CONFIGURATION
//  MDU_CANCEL_EN defined: adds input cancel (exception/flush from later stage).
//    cancel=1 with start: start output forced 0, nothing launched.
//    cancel=1 while busy: cnt<=0 next edge, HI/LO keep pre-op values, temps discarded.
//    cancel=1 with mthi/mtlo: write suppressed.
//    cancel on the commit edge (cnt==1) also suppresses the commit.
//  MDU_CANCEL_EN undefined: no cancel port; every accepted op commits.
// TESTING
//  1 reset_n=0 mid-div (cnt=6) -> hi=lo=0, busy=0 immediately; no commit after release.
//  2 mult a=0xFFFFFFFE b=3 -> busy 5 cycles; hi=0xFFFFFFFF lo=0xFFFFFFFA; multu same
//    operands -> hi=0x00000002 lo=0xFFFFFFFA.
//  3 div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    divu a=7 b=0 -> hi/lo unchanged after 10 busy cycles.
//  4 mthi a=0x12345678 then mflo/mfhi next cycle -> rdata=0x12345678 for mfhi; no busy.
//  5 mult issued in cycle busy falls -> accepted; mtlo sent while busy -> ignored.
//  6 (MDU_CANCEL_EN) mult start, cancel at busy cycle 3 -> busy=0 next cycle, hi/lo
//    unchanged; cancel at commit edge -> no commit.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - E-stage multiply/divide unit operand/result bundle.
// The cancel signal exists only when MDU_CANCEL_EN is defined.
interface mult_div_unit_if;
    logic        en;
    logic [3:0]  mult_divop;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

`ifdef MDU_CANCEL_EN
    modport master (output en, mult_divop, a, b, cancel,
                    input  start, busy, hi, lo, rdata);
    modport slave  (input  en, mult_divop, a, b, cancel,
                    output start, busy, hi, lo, rdata);
`else
    modport master (output en, mult_divop, a, b,
                    input  start, busy, hi, lo, rdata);
    modport slave  (input  en, mult_divop, a, b,
                    output start, busy, hi, lo, rdata);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle mult/div unit owning architectural HI/LO.
// Optional MDU_CANCEL_EN adds a cancel input that aborts launches, writes and commits.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic             clk,
    input logic             reset_n,
    mult_div_unit_if.slave  md
);
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;
    localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_hi_tmp;
    logic [31:0] r_lo_tmp;
    logic        r_wr_ok;

    logic        w_cancel;
    logic        w_busy;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_start;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

`ifdef MDU_CANCEL_EN
    assign w_cancel = md.cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_busy   = (r_cnt != 4'd0);
    assign w_is_mul = (md.mult_divop == OP_MULT) || (md.mult_divop == OP_MULTU);
    assign w_is_div = (md.mult_divop == OP_DIV)  || (md.mult_divop == OP_DIVU);
    assign w_start  = md.en && (w_is_mul || w_is_div) && !w_busy && !w_cancel;

    // Sign-extending to 64 bits makes the low 64 bits of the product correct for signed mult.
    assign w_prod = (md.mult_divop == OP_MULT)
                  ? ({{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b})
                  : ({32'd0, md.a} * {32'd0, md.b});

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    assign w_a_neg = (md.mult_divop == OP_DIV) && md.a[31];
    assign w_b_neg = (md.mult_divop == OP_DIV) && md.b[31];
    assign w_a_mag = w_a_neg ? -md.a : md.a;
    assign w_b_mag = w_b_neg ? -md.b : md.b;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quot  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem   = w_a_neg ? -w_r_mag : w_r_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 4'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_wr_ok  <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= w_is_mul ? LP_MULT_N : LP_DIV_N;
            r_hi_tmp <= w_is_mul ? w_prod[63:32] : w_rem;
            r_lo_tmp <= w_is_mul ? w_prod[31:0]  : w_quot;
            r_wr_ok  <= w_is_mul || (md.b != 32'd0);
        end else if (w_busy) begin
            if (w_cancel) begin
                r_cnt    <= 4'd0;
                r_hi_tmp <= 32'd0;
                r_lo_tmp <= 32'd0;
                r_wr_ok  <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1 && r_wr_ok) begin
                    r_hi <= r_hi_tmp;
                    r_lo <= r_lo_tmp;
                end
            end
        end else if (md.en && !w_cancel) begin
            if (md.mult_divop == OP_MTHI) r_hi <= md.a;
            if (md.mult_divop == OP_MTLO) r_lo <= md.a;
        end
    end

    assign md.start = w_start;
    assign md.busy  = w_busy;
    assign md.hi    = r_hi;
    assign md.lo    = r_lo;
    assign md.rdata = (md.mult_divop == OP_MFHI) ? r_hi :
                      (md.mult_divop == OP_MFLO) ? r_lo : 32'd0;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit.
// Define MDU_CANCEL_EN on both RTL and bench to exercise cancel.
module tb_mult_div_unit;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          ncyc;
    } exp_t;
    exp_t sb[$];

    mult_div_unit_if md_if ();

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a falling busy marks a finished operation; compare against the queue head.
    logic prev_busy;
    int   busy_len;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (md_if.busy) begin
                busy_len++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_commit: got hi=%h lo=%h expected no operation", md_if.hi, md_if.lo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("commit_hi", md_if.hi, e.hi);
                    chk("commit_lo", md_if.lo, e.lo);
                    chk("busy_cycles", 32'(busy_len), 32'(e.ncyc));
                end
                busy_len = 0;
            end
            prev_busy = md_if.busy;
        end
    end

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int n);
        exp_t e;
        e.hi = h; e.lo = l; e.ncyc = n;
        sb.push_back(e);
    endtask

    // Called at posedge+1; holds the op for one cycle and returns at the next posedge+1.
    task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic exp_start, input logic [31:0] exp_rdata, input string nm);
        md_if.en = 1'b1; md_if.mult_divop = op; md_if.a = av; md_if.b = bv;
        #1;
        chk({nm, "_start"}, 32'(md_if.start), 32'(exp_start));
        chk({nm, "_rdata"}, md_if.rdata, exp_rdata);
        @(posedge clk); #1;
        md_if.en = 1'b0; md_if.mult_divop = 4'd0; md_if.a = 32'd0; md_if.b = 32'd0;
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (!md_if.busy) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0 within 40 cycles", nm);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        md_if.en = 1'b0; md_if.mult_divop = 4'd0; md_if.a = 32'd0; md_if.b = 32'd0;
`ifdef MDU_CANCEL_EN
        md_if.cancel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", md_if.hi, 32'd0);
        chk("rst_lo", md_if.lo, 32'd0);
        chk("rst_busy", 32'(md_if.busy), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        drive(4'b0111, 32'h12345678, 32'd0, 1'b0, 32'd0, "mthi");
        chk("mthi_busy", 32'(md_if.busy), 32'd0);
        drive(4'b0110, 32'd0, 32'd0, 1'b0, 32'd0, "mflo_after_mthi");
        drive(4'b0101, 32'd0, 32'd0, 1'b0, 32'h12345678, "mfhi_after_mthi");
        drive(4'b1000, 32'h0BADF00D, 32'd0, 1'b0, 32'd0, "mtlo");
        drive(4'b0110, 32'd0, 32'd0, 1'b0, 32'h0BADF00D, "mflo_after_mtlo");

        // Asynchronous reset with the divider counter at 6.
        drive(4'b0010, 32'd100, 32'd7, 1'b1, 32'd0, "div_pre_reset");
        repeat (4) @(posedge clk);
        #1;
        chk("mid_div_busy", 32'(md_if.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hi", md_if.hi, 32'd0);
        chk("mid_rst_lo", md_if.lo, 32'd0);
        chk("mid_rst_busy", 32'(md_if.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_hi", md_if.hi, 32'd0);
        chk("post_rst_lo", md_if.lo, 32'd0);
        chk("post_rst_busy", 32'(md_if.busy), 32'd0);

        // mult, ignored mtlo while busy, back-to-back multu in the first idle cycle.
        push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        drive(4'b0001, 32'hFFFFFFFE, 32'd3, 1'b1, 32'd0, "mult");
        drive(4'b1000, 32'hDEADBEEF, 32'd0, 1'b0, 32'd0, "mtlo_busy");
        drive(4'b0011, 32'hFFFFFFFE, 32'd3, 1'b0, 32'd0, "multu_busy");
        wait_idle("mult");
        push(32'h00000002, 32'hFFFFFFFA, 5);
        drive(4'b0011, 32'hFFFFFFFE, 32'd3, 1'b1, 32'd0, "multu");
        wait_idle("multu");

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        drive(4'b0010, 32'hFFFFFFF9, 32'd2, 1'b1, 32'd0, "div_neg7_2");
        wait_idle("div_neg7_2");
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        drive(4'b0100, 32'd7, 32'd0, 1'b1, 32'd0, "divu_by0");
        wait_idle("divu_by0");
        push(32'h00000000, 32'h80000000, 10);
        drive(4'b0010, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, "div_ovf");
        wait_idle("div_ovf");
        push(32'h0000000F, 32'h0FFFFFFF, 10);
        drive(4'b0100, 32'hFFFFFFFF, 32'h10, 1'b1, 32'd0, "divu_big");
        wait_idle("divu_big");
        push(32'hFFFFFFFF, 32'h00000003, 10);
        drive(4'b0010, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd0, "div_neg7_neg2");
        wait_idle("div_neg7_neg2");

        // Bubbles and undefined opcodes.
        md_if.en = 1'b0; md_if.mult_divop = 4'b0001; md_if.a = 32'd9; md_if.b = 32'd9;
        #1;
        chk("bubble_start", 32'(md_if.start), 32'd0);
        @(posedge clk); #1;
        md_if.mult_divop = 4'd0;
        chk("bubble_busy", 32'(md_if.busy), 32'd0);
        drive(4'b1111, 32'h55555555, 32'd1, 1'b0, 32'd0, "undef_op");
        chk("undef_busy", 32'(md_if.busy), 32'd0);
        drive(4'b0101, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, "mfhi_final");

`ifdef MDU_CANCEL_EN
        md_if.cancel = 1'b1;
        drive(4'b0001, 32'd2, 32'd3, 1'b0, 32'd0, "cancel_start");
        drive(4'b0111, 32'hAAAA5555, 32'd0, 1'b0, 32'd0, "cancel_mthi");
        md_if.cancel = 1'b0;
        chk("cancel_mthi_hi", md_if.hi, 32'hFFFFFFFF);
        push(32'hFFFFFFFF, 32'h00000003, 3);
        drive(4'b0001, 32'd2, 32'd3, 1'b1, 32'd0, "mult_cancel3");
        @(posedge clk); #1;
        md_if.cancel = 1'b1;
        @(posedge clk); #1;
        md_if.cancel = 1'b0;
        chk("cancel3_busy", 32'(md_if.busy), 32'd0);
        push(32'hFFFFFFFF, 32'h00000003, 5);
        drive(4'b0001, 32'd2, 32'd3, 1'b1, 32'd0, "mult_cancel_commit");
        repeat (4) @(posedge clk);
        #1;
        md_if.cancel = 1'b1;
        @(posedge clk); #1;
        md_if.cancel = 1'b0;
        chk("cancel_commit_busy", 32'(md_if.busy), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
